// File: rtl/snake_body.sv
// rtl/snake_body.sv - snake segment buffer, move/check/over FSM and scan-pixel hit detect
// Optional build macro SNAKE_SELF_COLLISION_EN adds head-vs-body loss detection.
module snake_body #(
  parameter int MAX_LEN  = 96,
  parameter int WIN_LEN  = 95,
  parameter int LimHIzq  = 192,
  parameter int LimHDer  = 448,
  parameter int LimVUp   = 112,
  parameter int LimVDown = 368,
  parameter int START_X  = 320,
  parameter int START_Y  = 240
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iTick,
  input  logic [1:0]  iDirection,
  input  logic [10:0] iFoodLocationX,
  input  logic [10:0] iFoodLocationY,
  input  logic [10:0] iPixelRow,
  input  logic [10:0] iPixelCol,
  output logic [7:0]  oSnakeLenght,
  output logic        oRandEn,
  output logic        oGameOver,
  output logic [1:0]  oSnakePixel
);

  typedef enum logic [1:0] {RUN, CHECK, OVER} state_t;

  localparam logic [10:0] X_MIN   = 11'(LimHIzq);
  localparam logic [10:0] X_MAX   = 11'(LimHDer);
  localparam logic [10:0] Y_MIN   = 11'(LimVUp);
  localparam logic [10:0] Y_MAX   = 11'(LimVDown);
  localparam logic [10:0] X_START = 11'(START_X);
  localparam logic [10:0] Y_START = 11'(START_Y);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);
  localparam logic [7:0]  LEN_WIN = 8'(WIN_LEN);

  state_t      state;
  logic [1:0]  dir;
  logic [10:0] seg_x [MAX_LEN];
  logic [10:0] seg_y [MAX_LEN];

  logic [1:0]  new_dir;
  logic [10:0] head_x_nxt;
  logic [10:0] head_y_nxt;
  logic        wall_loss;
  logic        self_hit;
  logic        food_hit;
  logic [7:0]  grown_len;
  logic        pix_hit;

  // A request for the exact opposite direction keeps the current heading.
  always_comb begin
    new_dir    = (iDirection == {dir[1], ~dir[0]}) ? dir : iDirection;
    head_x_nxt = seg_x[0];
    head_y_nxt = seg_y[0];
    case (new_dir)
      2'b00: head_y_nxt = seg_y[0] - 11'd1;
      2'b01: head_y_nxt = seg_y[0] + 11'd1;
      2'b10: head_x_nxt = seg_x[0] - 11'd1;
      default: head_x_nxt = seg_x[0] + 11'd1;
    endcase
  end

  always_comb begin
    wall_loss = (seg_x[0] < X_MIN) || (seg_x[0] > X_MAX) ||
                (seg_y[0] < Y_MIN) || (seg_y[0] > Y_MAX);
    food_hit  = (seg_x[0] == iFoodLocationX) && (seg_y[0] == iFoodLocationY);
    grown_len = (oSnakeLenght < LEN_MAX) ? oSnakeLenght + 8'd1 : oSnakeLenght;
  end

`ifdef SNAKE_SELF_COLLISION_EN
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i < int'(oSnakeLenght) && seg_x[i] == seg_x[0] && seg_y[i] == seg_y[0])
        self_hit = 1'b1;
    end
  end
`else
  assign self_hit = 1'b0;
`endif

  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(oSnakeLenght) && seg_x[i] == iPixelCol && seg_y[i] == iPixelRow)
        pix_hit = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= RUN;
      dir          <= 2'b11;
      oSnakeLenght <= 8'd3;
      oRandEn      <= 1'b0;
      oGameOver    <= 1'b0;
      seg_x[0]     <= X_START;
      seg_y[0]     <= Y_START;
      seg_x[1]     <= X_START - 11'd1;
      seg_y[1]     <= Y_START;
      for (int i = 2; i < MAX_LEN; i++) begin
        seg_x[i] <= X_START - 11'd2;
        seg_y[i] <= Y_START;
      end
    end else begin
      oRandEn <= 1'b0;
      case (state)
        RUN: begin
          if (iTick) begin
            dir      <= new_dir;
            seg_x[0] <= head_x_nxt;
            seg_y[0] <= head_y_nxt;
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            state <= CHECK;
          end
        end
        CHECK: begin
          // Loss takes priority over a simultaneous food match.
          if (wall_loss || self_hit) begin
            state     <= OVER;
            oGameOver <= 1'b1;
          end else if (food_hit) begin
            oSnakeLenght <= grown_len;
            oRandEn      <= 1'b1;
            if (grown_len >= LEN_WIN) begin
              state     <= OVER;
              oGameOver <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        default: state <= OVER;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) oSnakePixel <= 2'b00;
    else       oSnakePixel <= {1'b0, pix_hit};
  end

endmodule

// File: tb/tb_snake_body.sv
// tb/tb_snake_body.sv - randomized and directed bench for snake_body against a queue-based model
module tb_snake_body;

  localparam int MAX_LEN = 96, WIN_LEN = 95;
  localparam int XL = 192, XH = 448, YL = 112, YH = 368, SX = 320, SY = 240;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iTick = 1'b0;
  logic [1:0]  iDirection = 2'b11;
  logic [10:0] iFoodLocationX = '0, iFoodLocationY = '0;
  logic [10:0] iPixelRow = '0, iPixelCol = '0;
  logic [7:0]  oSnakeLenght;
  logic        oRandEn, oGameOver;
  logic [1:0]  oSnakePixel;

  snake_body dut (
    .Clock(Clock), .Reset(Reset), .iTick(iTick), .iDirection(iDirection),
    .iFoodLocationX(iFoodLocationX), .iFoodLocationY(iFoodLocationY),
    .iPixelRow(iPixelRow), .iPixelCol(iPixelCol),
    .oSnakeLenght(oSnakeLenght), .oRandEn(oRandEn), .oGameOver(oGameOver),
    .oSnakePixel(oSnakePixel)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: body as a list of coordinates, head first.
  int bx[$], by[$];
  int mlen, mdir, mrand;
  bit mcheck, mover;

`ifdef SNAKE_SELF_COLLISION_EN
  localparam bit SELF_EN = 1'b1;
`else
  localparam bit SELF_EN = 1'b0;
`endif

  function automatic void model_reset();
    bx.delete(); by.delete();
    for (int i = 0; i < MAX_LEN; i++) begin
      bx.push_back(i == 0 ? SX : (i == 1 ? SX - 1 : SX - 2));
      by.push_back(SY);
    end
    mlen = 3; mdir = 3; mrand = 0; mcheck = 0; mover = 0;
  endfunction

  function automatic int eff_dir(input int d);
    return (d / 2 == mdir / 2 && d != mdir) ? mdir : d;
  endfunction

  function automatic void next_head(input int d, output int x, output int y);
    x = bx[0]; y = by[0];
    case (eff_dir(d))
      0: y = y - 1;
      1: y = y + 1;
      2: x = x - 1;
      default: x = x + 1;
    endcase
  endfunction

  function automatic int pix_model(input int row, input int col);
    for (int i = 0; i < mlen; i++)
      if (bx[i] == col && by[i] == row) return 1;
    return 0;
  endfunction

  function automatic void model_step(input bit tick, input int d, input int fx, input int fy);
    bit loss;
    int hx, hy;
    mrand = 0;
    if (mover) return;
    if (mcheck) begin
      mcheck = 0;
      loss = bx[0] < XL || bx[0] > XH || by[0] < YL || by[0] > YH;
      if (SELF_EN)
        for (int i = 1; i < mlen; i++)
          if (bx[i] == bx[0] && by[i] == by[0]) loss = 1;
      if (loss) mover = 1;
      else if (bx[0] == fx && by[0] == fy) begin
        if (mlen < MAX_LEN) mlen++;
        mrand = 1;
        if (mlen >= WIN_LEN) mover = 1;
      end
    end else if (tick) begin
      next_head(d, hx, hy);
      mdir = eff_dir(d);
      bx.push_front(hx & 11'h7ff); by.push_front(hy & 11'h7ff);
      void'(bx.pop_back()); void'(by.pop_back());
      mcheck = 1;
    end
  endfunction

  task automatic cycle(input bit tick, input int d);
    int pexp;
    iTick = tick; iDirection = 2'(d);
    pexp = pix_model(int'(iPixelRow), int'(iPixelCol));
    @(posedge Clock);
    model_step(tick, d, int'(iFoodLocationX), int'(iFoodLocationY));
    @(negedge Clock);
    iTick = 1'b0;
    chk("len", oSnakeLenght, mlen);
    chk("randen", oRandEn, mrand);
    chk("gameover", oGameOver, mover);
    chk("pixel", oSnakePixel, pexp);
  endtask

  task automatic move(input int d);
    cycle(1, d);
    cycle(0, d);
  endtask

  task automatic probe(input string tag, input int col, input int row, input int exp);
    iPixelCol = 11'(col); iPixelRow = 11'(row);
    cycle(0, 3);
    chk(tag, oSnakePixel, exp);
  endtask

  task automatic food_ahead(input int d);
    int x, y;
    next_head(d, x, y);
    iFoodLocationX = 11'(x); iFoodLocationY = 11'(y);
  endtask

  task automatic do_reset();
    iTick = 1'b0; Reset = 1'b1;
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    chk("rst_len", oSnakeLenght, 3);
    chk("rst_randen", oRandEn, 0);
    chk("rst_gameover", oGameOver, 0);
    chk("rst_pixel", oSnakePixel, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset();

    // First tick right
    iFoodLocationX = 0; iFoodLocationY = 0;
    move(3);
    chk("t1_len", oSnakeLenght, 3);
    chk("t1_randen", oRandEn, 0);
    chk("t1_gameover", oGameOver, 0);
    probe("t1_head", 321, 240, 1);

    // Eat one step right, check single-cycle pulse and tail
    do_reset();
    iFoodLocationX = 321; iFoodLocationY = 240;
    cycle(1, 3);
    cycle(0, 3);
    chk("eat_randen", oRandEn, 1);
    chk("eat_len", oSnakeLenght, 4);
    iFoodLocationX = 0; iFoodLocationY = 0;
    probe("eat_tail", 318, 240, 1);
    chk("eat_randen_drop", oRandEn, 0);

    // Wall at right bound
    do_reset();
    for (int i = 0; i < 128; i++) move(3);
    probe("wall_head448", 448, 240, 1);
    chk("wall_running", oGameOver, 0);
    move(3);
    chk("wall_over", oGameOver, 1);
    for (int i = 0; i < 4; i++) move(i % 4);
    chk("over_len", oSnakeLenght, 3);
    probe("over_head_visible", 449, 240, 1);

    // Reverse request ignored
    do_reset();
    move(3);
    move(2);
    probe("reverse_head", 322, 240, 1);

    // Win by eating to WIN_LEN
    do_reset();
    for (int i = 0; i < 91; i++) begin food_ahead(3); move(3); end
    chk("win_len94", oSnakeLenght, 94);
    chk("win_running", oGameOver, 0);
    food_ahead(3);
    cycle(1, 3);
    cycle(0, 3);
    chk("win_len95", oSnakeLenght, 95);
    chk("win_randen", oRandEn, 1);
    chk("win_over", oGameOver, 1);

    // Self collision with length 5
    do_reset();
    food_ahead(3); move(3);
    food_ahead(3); move(3);
    iFoodLocationX = 0; iFoodLocationY = 0;
    move(0); move(2); move(1);
    chk("self_len", oSnakeLenght, 5);
    chk("self_over", oGameOver, SELF_EN ? 1 : 0);
    probe("self_head_pix", 321, 240, 1);

    // Reset asserted during CHECK aborts the move and eat
    do_reset();
    food_ahead(3);
    cycle(1, 3);
    Reset = 1'b1;
    #2;
    chk("async_len", oSnakeLenght, 3);
    chk("async_randen", oRandEn, 0);
    chk("async_pixel", oSnakePixel, 0);
    do_reset();
    iFoodLocationX = 0; iFoodLocationY = 0;
    probe("async_head", 320, 240, 1);

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int c = 0; c < 300 && !mover; c++) begin
        int d, k;
        d = int'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) food_ahead(d);
        else begin
          iFoodLocationX = 11'($urandom_range(XL, XH));
          iFoodLocationY = 11'($urandom_range(YL, YH));
        end
        if ($urandom_range(0, 1) == 1) begin
          k = int'($urandom_range(0, mlen - 1));
          iPixelCol = 11'(bx[k]); iPixelRow = 11'(by[k]);
        end else begin
          iPixelCol = 11'($urandom_range(XL, XH));
          iPixelRow = 11'($urandom_range(YL, YH));
        end
        cycle($urandom_range(0, 2) != 0, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL have parameter MAX_LEN, default 96: segment buffer depth, in segments.
REQ-002 SHALL have parameter WIN_LEN, default 95: length that ends the game as a win.
REQ-003 SHALL have parameters LimHIzq/LimHDer/LimVUp/LimVDown, defaults 192/448/112/368: inclusive playfield bounds, in pixels.
REQ-004 SHALL have parameters START_X/START_Y, defaults 320/240: head position after reset.
REQ-005 Clock  in  1  single system clock, all state on rising edge.
REQ-006 Reset  in  1  reset is asynchronous and active-high.
REQ-007 iTick  in  1  one-cycle move strobe.
REQ-008 iDirection  in  2  00 up, 01 down, 10 left, 11 right.
REQ-009 iFoodLocationX / iFoodLocationY  in  11 each  current food pixel from the world block.
REQ-010 iPixelRow / iPixelCol  in  11 each  VGA scan position.
REQ-011 oSnakeLenght  out  8  active segment count.
REQ-012 oRandEn  out  1  one-cycle pulse requesting a new food location.
REQ-013 oGameOver  out  1  game ended (loss or win).
REQ-014 oSnakePixel  out  2  01 when the scan pixel hits an active segment, else 00.

Function
REQ-015 SHALL hold segments 0..MAX_LEN-1 as 11-bit X/Y pairs; segment 0 is the head; the first oSnakeLenght segments are active.
REQ-016 FSM states SHALL be RUN, CHECK and OVER.
REQ-017 RUN + iTick SHALL latch iDirection, unless it is the reverse of the current direction, in which case the current direction is kept.
REQ-018 In the same RUN + iTick cycle, segment[i] SHALL take segment[i-1] for i=1..MAX_LEN-1, the head SHALL step exactly 1 pixel, and the FSM SHALL go to CHECK.
REQ-019 Up SHALL be row-1, down row+1, left col-1, right col+1; there is no wrap-around.
REQ-020 CHECK SHALL last exactly one cycle; iTick arriving in CHECK is dropped.
REQ-021 Loss: in CHECK, head col<LimHIzq, col>LimHDer, row<LimVUp or row>LimVDown SHALL go to OVER with oGameOver=1 on the next edge.
REQ-022 Eat: in CHECK without loss, head equal to (iFoodLocationX, iFoodLocationY) SHALL increment oSnakeLenght (saturating at MAX_LEN) and pulse oRandEn for exactly one cycle.
REQ-023 Growth SHALL expose the previous tail, which the shift in REQ-018 already kept; no extra cycle is used.
REQ-024 Win: an eat that brings the length to >= WIN_LEN SHALL go to OVER with oGameOver=1; oRandEn still pulses.
REQ-025 Neither loss nor eat SHALL return the FSM to RUN.
REQ-026 If loss and food match coincide, loss SHALL win: no oRandEn pulse, length unchanged.
REQ-027 OVER SHALL ignore iTick and iDirection, keep segments and length frozen, and be left only by Reset.
REQ-028 oSnakePixel SHALL be registered with 1-cycle latency from iPixelRow/iPixelCol: compare against all active segments in parallel, 01 on any match, 00 when none.
REQ-029 oSnakePixel SHALL stay driven in OVER so the frozen body remains visible.

Reset
REQ-030 Reset SHALL be asynchronous and active-high; assertion at any point, including mid-CHECK, SHALL abort the move.
REQ-031 Reset SHALL force: FSM=RUN, direction=right, head=(START_X,START_Y), segment1=(START_X-1,START_Y), segment2=(START_X-2,START_Y), all other segments=(START_X-2,START_Y).
REQ-032 Reset SHALL force oSnakeLenght=3, oRandEn=0, oGameOver=0, oSnakePixel=00.

Configuration
REQ-033 Macro SNAKE_SELF_COLLISION_EN defined: in CHECK, head equal to any active segment 1..oSnakeLenght-1 SHALL be a loss, handled like REQ-021 with loss priority per REQ-026.
REQ-034 SNAKE_SELF_COLLISION_EN undefined: no self-collision compare logic SHALL be built; only wall losses and wins end the game.

Verification
REQ-035 Reset, then 1 tick with dir=11 -> head (321,240), length 3, oRandEn 0, oGameOver 0.
REQ-036 Head (320,240), dir right, food (321,240), tick -> oRandEn high for exactly 1 cycle, length 4, tail still (318,240).
REQ-037 Dir right, 128 ticks from reset -> head col 448, game running; 129th tick -> oGameOver=1; further ticks -> no change.
REQ-038 Moving right, drive dir=10 with tick -> head still moves right (reverse ignored).
REQ-039 Length 94, eat on next tick -> length 95, oRandEn pulse, oGameOver=1.
REQ-040 Snake of length 5 turning up, left, down into itself -> oGameOver=1 with macro defined, 0 without; scan pixel at head -> oSnakePixel 01 one cycle later.
